// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache controller.
package dcache_pkg;

  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned IDX_W_DEF  = 3;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    WR_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid bits, tags and one data word per line.
// Provides one combinational read port and one write port.
module dcache_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid_c,
  output logic [TAG_W-1:0]  rd_tag_c,
  output logic [DATA_W-1:0] rd_data_c,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int unsigned LINES = 2 ** IDX_W;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  // Only the valid bits are cleared; stale tags/data are masked by valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid_c = valid[rd_idx];
  assign rd_tag_c   = tag_mem[rd_idx];
  assign rd_data_c  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller with
// blocking miss handling and saturating read hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_cen,
  input  logic              core_wen,
  input  logic              core_oen,
  input  logic [ADDR_W-1:0] core_a,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  state_t            state;
  state_t            prev_state;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  logic              req_wr_c;
  logic              req_rd_c;
  logic              hit_c;
  logic              rd_hit_c;
  logic              arr_we_c;
  logic              rd_valid_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [TAG_W-1:0]  cmp_tag_c;
  logic [TAG_W-1:0]  rd_tag_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [DATA_W-1:0] arr_wdata_c;

  assign req_wr_c = !core_cen && !core_wen;
  assign req_rd_c = !core_cen && core_wen && !core_oen;

  // Lookup uses the live core address in IDLE, the latched one while waiting.
  assign rd_idx_c  = (state == IDLE) ? core_a[IDX_W-1:0]        : lat_addr[IDX_W-1:0];
  assign cmp_tag_c = (state == IDLE) ? core_a[ADDR_W-1:IDX_W]   : lat_addr[ADDR_W-1:IDX_W];
  assign hit_c     = rd_valid_c && (rd_tag_c == cmp_tag_c);
  assign rd_hit_c  = (state == IDLE) && req_rd_c && hit_c;

  // Refill always allocates; a completed store only updates a line it hits.
  assign arr_we_c    = rst_n && mem_ack &&
                       ((state == RD_WAIT) || ((state == WR_WAIT) && hit_c));
  assign arr_wdata_c = (state == RD_WAIT) ? mem_rdata : lat_data;

  dcache_array #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (rd_idx_c),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_data_c  (rd_data_c),
    .we         (arr_we_c),
    .wr_idx     (lat_addr[IDX_W-1:0]),
    .wr_tag     (lat_addr[ADDR_W-1:IDX_W]),
    .wr_data    (arr_wdata_c)
  );

  // Stall and load data must react in the request cycle, so they are combinational.
  always_comb begin
    core_stall = 1'b0;
    core_rdata = '0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          core_stall = req_wr_c || (req_rd_c && !hit_c);
          if (rd_hit_c) begin
            core_rdata = rd_data_c;
          end
        end
        RD_WAIT, WR_WAIT: core_stall = 1'b1;
        default:          core_stall = 1'b0;
      endcase
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_state <= IDLE;
      lat_addr   <= '0;
      lat_data   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      prev_state <= state;
      case (state)
        IDLE: begin
          if (req_wr_c) begin
            lat_addr <= core_a;
            lat_data <= core_wdata;
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            state    <= WR_WAIT;
          end else if (req_rd_c && !hit_c) begin
            lat_addr <= core_a;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            state    <= RD_WAIT;
            if (miss_cnt != '1) begin
              miss_cnt <= miss_cnt + CNT_W'(1);
            end
          end else if (rd_hit_c && (prev_state != RD_WAIT) && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
          end
        end
        RD_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        WR_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= WR_DONE;
          end
        end
        WR_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized
// traffic against a transaction-level cache/memory model.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst_n;
  logic        core_cen;
  logic        core_wen;
  logic        core_oen;
  logic [6:0]  core_a;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        mem_req;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: line contents, backing memory, expected counters.
  bit          m_valid [8];
  logic [3:0]  m_tag   [8];
  logic [31:0] m_data  [8];
  logic [31:0] mem_model [128];
  int          m_hit_cnt;
  int          m_miss_cnt;

  dcache_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_cen   (core_cen),
    .core_wen   (core_wen),
    .core_oen   (core_oen),
    .core_a     (core_a),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_hit(input logic [6:0] addr);
    return m_valid[addr[2:0]] && (m_tag[addr[2:0]] == addr[6:3]);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_hit_cnt  = 0;
    m_miss_cnt = 0;
  endfunction

  task automatic do_read(input logic [6:0] addr, input int lat);
    int idx;
    int stalls;
    bit exp_hit;
    idx     = int'(addr[2:0]);
    exp_hit = model_hit(addr);
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    core_cen = 1'b0; core_wen = 1'b1; core_oen = 1'b0; core_a = addr; core_wdata = $urandom;
    #1;
    checks++;
    if (exp_hit) begin
      if (core_stall !== 1'b0 || core_rdata !== m_data[idx]) begin
        errors++;
        $display("FAIL rd_hit a=%h: stall=%b rdata=%h, expected stall=0 rdata=%h",
                 addr, core_stall, core_rdata, m_data[idx]);
      end
      if (m_hit_cnt < 65535) m_hit_cnt++;
    end else begin
      if (core_stall !== 1'b1 || core_rdata !== 32'h0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL rd_miss a=%h: stall=%b rdata=%h req=%b, expected stall=1 rdata=0 req=0",
                 addr, core_stall, core_rdata, mem_req);
      end
      if (m_miss_cnt < 65535) m_miss_cnt++;
      stalls = (core_stall === 1'b1) ? 1 : 0;
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        mem_ack   = (k == lat);
        mem_rdata = (k == lat) ? mem_model[addr] : $urandom;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== addr ||
            core_stall !== 1'b1 || core_rdata !== 32'h0) begin
          errors++;
          $display("FAIL rd_wait a=%h k=%0d: req=%b we=%b maddr=%h stall=%b rdata=%h, expected 1 0 %h 1 0",
                   addr, k, mem_req, mem_we, mem_addr, core_stall, core_rdata, addr);
        end
        if (core_stall === 1'b1) stalls++;
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      m_valid[idx] = 1'b1; m_tag[idx] = addr[6:3]; m_data[idx] = mem_model[addr];
      #1;
      checks++;
      if (core_stall !== 1'b0 || core_rdata !== m_data[idx] || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL rd_refill a=%h: stall=%b rdata=%h req=%b, expected stall=0 rdata=%h req=0",
                 addr, core_stall, core_rdata, mem_req, m_data[idx]);
      end
      checks++;
      if (stalls != lat + 1) begin
        errors++;
        $display("FAIL miss_penalty a=%h: stalled %0d cycles, expected %0d", addr, stalls, lat + 1);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (hit_cnt !== 16'(m_hit_cnt) || miss_cnt !== 16'(m_miss_cnt)) begin
      errors++;
      $display("FAIL rd_counters a=%h: hit=%0d miss=%0d, expected hit=%0d miss=%0d",
               addr, hit_cnt, miss_cnt, m_hit_cnt, m_miss_cnt);
    end
  endtask

  task automatic do_write(input logic [6:0] addr, input logic [31:0] data, input int lat,
                          input bit spurious);
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    core_cen = 1'b0; core_wen = 1'b0; core_oen = 1'($urandom_range(0, 1));
    core_a = addr; core_wdata = data;
    #1;
    checks++;
    if (core_stall !== 1'b1 || core_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_issue a=%h: stall=%b rdata=%h, expected stall=1 rdata=0",
               addr, core_stall, core_rdata);
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      mem_ack = (k == lat); mem_rdata = $urandom;
      core_wdata = $urandom;
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== addr || mem_wdata !== data ||
          core_stall !== 1'b1) begin
        errors++;
        $display("FAIL wr_wait a=%h k=%0d: req=%b we=%b maddr=%h mwdata=%h stall=%b, expected 1 1 %h %h 1",
                 addr, k, mem_req, mem_we, mem_addr, mem_wdata, core_stall, addr, data);
      end
    end
    mem_model[addr] = data;
    if (model_hit(addr)) m_data[addr[2:0]] = data;
    @(negedge clk);
    mem_ack = spurious;
    #1;
    checks++;
    if (core_stall !== 1'b0 || mem_req !== 1'b0 || core_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_done a=%h: stall=%b req=%b rdata=%h, expected 0 0 0",
               addr, core_stall, mem_req, core_rdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || hit_cnt !== 16'(m_hit_cnt) || miss_cnt !== 16'(m_miss_cnt)) begin
      errors++;
      $display("FAIL wr_after a=%h: req=%b hit=%0d miss=%0d, expected req=0 hit=%0d miss=%0d",
               addr, mem_req, hit_cnt, miss_cnt, m_hit_cnt, m_miss_cnt);
    end
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      core_cen = 1'($urandom_range(0, 1)); core_wen = 1'b1; core_oen = 1'b1;
      core_a = 7'($urandom); mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      #1;
      checks++;
      if (core_stall !== 1'b0 || core_rdata !== 32'h0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL idle: stall=%b rdata=%h req=%b, expected 0 0 0", core_stall, core_rdata, mem_req);
      end
    end
    @(negedge clk);
    mem_ack = 1'b0; core_cen = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    core_cen = 1'b0; core_wen = 1'b1; core_oen = 1'b0; core_a = 7'h05;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (core_stall !== 1'b0 || mem_req !== 1'b0 || core_rdata !== 32'h0 ||
        hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset: stall=%b req=%b rdata=%h hit=%0d miss=%0d, expected all 0",
               core_stall, mem_req, core_rdata, hit_cnt, miss_cnt);
    end
    core_cen = 1'b1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_directed();
    do_read(7'h05, 3);
    checks++;
    if (core_rdata !== 32'hDEADBEEF || miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
      errors++;
      $display("FAIL first_miss: rdata=%h miss=%0d hit=%0d, expected deadbeef 1 0",
               core_rdata, miss_cnt, hit_cnt);
    end
    do_read(7'h05, 1);
    checks++;
    if (hit_cnt !== 16'd1) begin
      errors++;
      $display("FAIL repeat_hit: hit=%0d, expected 1", hit_cnt);
    end
    do_write(7'h05, 32'h12345678, 2, 1'b1);
    do_idle(2);
    do_read(7'h05, 1);
    checks++;
    if (core_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL write_hit_read: rdata=%h, expected 12345678", core_rdata);
    end
    do_read(7'h0D, 2);
    do_read(7'h05, 2);
    checks++;
    if (miss_cnt !== 16'd3) begin
      errors++;
      $display("FAIL evict: miss=%0d, expected 3", miss_cnt);
    end
    do_write(7'h22, 32'hCAFEF00D, 1, 1'b0);
    do_read(7'h22, 2);
    checks++;
    if (miss_cnt !== 16'd4 || core_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL write_no_alloc: miss=%0d rdata=%h, expected 4 cafef00d", miss_cnt, core_rdata);
    end
  endtask

  task automatic test_random(input int n);
    int op;
    logic [6:0] a;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 15));
      if (op < 5)      do_read(a, $urandom_range(1, 4));
      else if (op < 8) do_write(a, $urandom, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      else             do_idle($urandom_range(1, 3));
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] a;
    a = 7'h00;
    for (int i = 127; i >= 0; i--) if (!model_hit(7'(i))) a = 7'(i);
    @(negedge clk);
    mem_ack = 1'b0;
    core_cen = 1'b0; core_wen = 1'b1; core_oen = 1'b0; core_a = a;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || core_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre a=%h: req=%b stall=%b, expected 1 1", a, mem_req, core_stall);
    end
    @(negedge clk);
    rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
    #1;
    checks++;
    if (core_stall !== 1'b0 || core_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_during: stall=%b rdata=%h, expected 0 0", core_stall, core_rdata);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || core_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_req: req=%b stall=%b, expected 0 0", mem_req, core_stall);
    end
    @(negedge clk);
    rst_n = 1'b1; core_cen = 1'b1;
    model_reset();
    #1;
    checks++;
    if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_counters: hit=%0d miss=%0d req=%b, expected 0 0 0", hit_cnt, miss_cnt, mem_req);
    end
    do_read(a, 1);
    do_read(7'h05, 2);
    do_read(7'h22, 1);
    checks++;
    if (miss_cnt !== 16'd3 || hit_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_all_miss: miss=%0d hit=%0d, expected 3 0", miss_cnt, hit_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; core_cen = 1'b1; core_wen = 1'b1; core_oen = 1'b1;
    core_a = '0; core_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    for (int i = 0; i < 128; i++) mem_model[i] = $urandom;
    mem_model[5] = 32'hDEADBEEF;
    model_reset();
    test_reset();
    test_directed();
    test_random(300);
    test_reset_mid();
    test_random(100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL expose parameter ADDR_W, default 7, meaning core word-address width.
REQ-002 SHALL expose parameter DATA_W, default 32, meaning data word width.
REQ-003 SHALL expose parameter IDX_W, default 3, meaning index width (8 direct-mapped one-word lines); tag width = ADDR_W-IDX_W.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 core_cen  in  1  core request enable, active-low.
REQ-007 core_wen  in  1  core write enable, active-low.
REQ-008 core_oen  in  1  core read enable, active-low.
REQ-009 core_a  in  ADDR_W  core word address.
REQ-010 core_wdata  in  DATA_W  core store data.
REQ-011 core_rdata  out  DATA_W  load data to core.
REQ-012 core_stall  out  1  core must hold its request and PC while high.
REQ-013 mem_req  out  1  main-memory request, held until mem_ack.
REQ-014 mem_we  out  1  1 = memory write, 0 = memory read.
REQ-015 mem_addr  out  ADDR_W  memory word address.
REQ-016 mem_wdata  out  DATA_W  memory write data.
REQ-017 mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1.
REQ-018 mem_ack  in  1  single-cycle completion pulse.
REQ-019 hit_cnt, miss_cnt  out  16 each  read-hit / read-miss counters.

Function
REQ-020 Request present when core_cen=0; write when core_wen=0 (write wins if core_oen also 0); read when core_oen=0 and core_wen=1; else no-op.
REQ-021 Index = core_a[IDX_W-1:0]; tag = core_a[ADDR_W-1:IDX_W]; hit = line valid and tag equal.
REQ-022 FSM states: IDLE, RD_WAIT, WR_WAIT, WR_DONE.
REQ-023 IDLE, read hit: core_rdata = line data combinationally, core_stall=0, stay IDLE.
REQ-024 IDLE, read miss: core_stall=1 same cycle; latch address; next state RD_WAIT.
REQ-025 RD_WAIT: core_stall=1, mem_req=1, mem_we=0, mem_addr = latched address; on mem_ack fill line (valid=1, tag, mem_rdata), next state IDLE; following cycle is a hit (miss penalty = ack latency + 1 cycle).
REQ-026 IDLE, write (hit or miss): core_stall=1; latch address and data; next state WR_WAIT.
REQ-027 WR_WAIT: core_stall=1, mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values; on mem_ack update line data if latched address hits (write-through, no write-allocate), next state WR_DONE.
REQ-028 WR_DONE: core_stall=0, no memory request, request treated as complete (not reissued), next state IDLE unconditionally.
REQ-029 mem_req, mem_we, mem_addr, mem_wdata SHALL stay stable from assertion to the mem_ack cycle inclusive; mem_req=0 in IDLE and WR_DONE.
REQ-030 mem_ack in IDLE or WR_DONE SHALL be ignored.
REQ-031 core_rdata SHALL be 0 when not a read hit in IDLE.
REQ-032 miss_cnt increments on IDLE->RD_WAIT; hit_cnt increments on IDLE read hit unless previous state was RD_WAIT (refill completion not counted); both saturate at 0xFFFF.
REQ-033 No-op in IDLE: core_stall=0, no state change.

Reset
REQ-034 rst_n=0 at posedge: state IDLE, all valid bits 0, latches 0, hit_cnt=miss_cnt=0; data/tag arrays need not clear.
REQ-035 During reset, core_stall=0, mem_req=0, core_rdata=0.
REQ-036 Reset mid-transaction abandons the transaction; mem_req falls after the reset edge; no line filled or updated.

Structure
REQ-037 Package dcache_pkg SHALL hold the FSM state enum and ADDR_W/DATA_W/IDX_W defaults.
REQ-038 Storage (valid, tag, data arrays; one read port, one write port) SHALL be sub-module dcache_array; FSM, latches and counters stay in dcache_ctrl.

Verification
REQ-039 Read 0x05 after reset, mem_ack 3 cycles later with 0xDEADBEEF -> stall 4 cycles, then rdata=0xDEADBEEF, miss_cnt=1, hit_cnt=0.
REQ-040 Repeat read 0x05 -> stall=0 same cycle, rdata=0xDEADBEEF, hit_cnt=1.
REQ-041 Write 0x05=0x12345678, ack after 2 cycles -> mem_we=1, mem_addr=0x05, one WR_DONE cycle with stall=0, later read 0x05 hits with 0x12345678.
REQ-042 Read 0x0D (same index, tag 1) -> miss, refill evicts 0x05; read 0x05 afterwards misses again, miss_cnt=3.
REQ-043 Write miss 0x22 -> memory write issued, no allocate; read 0x22 misses.
REQ-044 rst_n low during RD_WAIT -> mem_req 0 next cycle, all reads miss after reset, counters 0.
